load_align_unit: RTL and testbench

//  Multi-cycle load data path sitting between MEM stage and writeback. Reads the

---
 rtl/load_align_unit_if.sv | 27 ++
 rtl/load_align_unit.sv | 135 +++++++++++++
 tb/tb_load_align_unit.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_align_unit_if.sv
// load_align_unit_if: request, data-memory read and response signals of the load align unit.
interface load_align_unit_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic [2:0]      req_load_type;
    logic [4:0]      req_rd;
    logic            mem_rd_en;
    logic [XLEN-1:0] mem_rd_addr;
    logic [XLEN-1:0] mem_rd_data;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;
    logic [4:0]      rsp_rd;
    logic            rsp_err;

    modport master (
        output req_valid, req_addr, req_load_type, req_rd, mem_rd_data,
        input  req_ready, mem_rd_en, mem_rd_addr, rsp_valid, rsp_data, rsp_rd, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_load_type, req_rd, mem_rd_data,
        output req_ready, mem_rd_en, mem_rd_addr, rsp_valid, rsp_data, rsp_rd, rsp_err
    );
endinterface

// File: rtl/load_align_unit.sv
// load_align_unit: multi-cycle load path; reads one or two memory words, merges
// word-crossing loads and returns sign/zero-extended data.
module load_align_unit #(
    parameter int XLEN        = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input logic clk,
    input logic rst_n,
    input logic flush,
    load_align_unit_if.slave bus
);
    localparam int BYTES = XLEN / 8;
    localparam int OFS   = $clog2(BYTES);

    typedef enum logic [2:0] {IDLE, RD0, RD1, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d, word0_q, word0_d, rsp_data_q, rsp_data_d;
    logic [2:0]      type_q, type_d;
    logic [4:0]      rd_q, rd_d, rsp_rd_q, rsp_rd_d;
    logic            cross_q, cross_d, rsp_err_q, rsp_err_d;
    logic [XLEN-1:0] base, merged, ext;
    logic [3:0]      sz;
    logic            illegal, misaligned, crossing, accept;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic signed [31:0] sw;

    // request decode, evaluated on the incoming request while idle
    always_comb begin
        sz = (bus.req_load_type == 3'd1 || bus.req_load_type == 3'd4) ? 4'd1 :
             (bus.req_load_type == 3'd2 || bus.req_load_type == 3'd5) ? 4'd2 :
             (bus.req_load_type == 3'd3 || bus.req_load_type == 3'd6) ? 4'd4 : 4'd8;
        illegal    = XLEN == 32 && bus.req_load_type[2:1] == 2'b11;
        misaligned = (4'(bus.req_addr[2:0]) & (sz - 4'd1)) != 4'd0;
        crossing   = 5'(bus.req_addr[OFS-1:0]) + 5'(sz) > 5'(BYTES);
        accept     = bus.req_valid && !flush && state_q == IDLE;
    end

    assign base = {addr_q[XLEN-1:OFS], {OFS{1'b0}}};

    // the last word is still on mem_rd_data in WAIT; word1 is zero for single-word loads
    always_comb begin
        merged = XLEN'({cross_q ? bus.mem_rd_data : {XLEN{1'b0}},
                        cross_q ? word0_q : bus.mem_rd_data} >> {addr_q[OFS-1:0], 3'b000});
        sb = merged[7:0];
        sh = merged[15:0];
        sw = merged[31:0];
        case (type_q)
            3'd1:    ext = XLEN'(sb);
            3'd2:    ext = XLEN'(sh);
            3'd3:    ext = XLEN'(sw);
            3'd4:    ext = XLEN'(merged[7:0]);
            3'd5:    ext = XLEN'(merged[15:0]);
            3'd6:    ext = XLEN'(merged[31:0]);
            default: ext = merged;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        type_d     = type_q;
        rd_d       = rd_q;
        cross_d    = cross_q;
        word0_d    = word0_q;
        rsp_data_d = rsp_data_q;
        rsp_rd_d   = rsp_rd_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept && bus.req_load_type != 3'd0) begin
                    addr_d  = bus.req_addr;
                    type_d  = bus.req_load_type;
                    rd_d    = bus.req_rd;
                    cross_d = crossing;
                    if (illegal || (misaligned && !MISALIGN_EN)) begin
                        state_d    = RESP;
                        rsp_data_d = '0;
                        rsp_rd_d   = bus.req_rd;
                        rsp_err_d  = 1'b1;
                    end else begin
                        state_d = RD0;
                    end
                end
            end
            RD0: state_d = flush ? IDLE : cross_q ? RD1 : WAIT;
            RD1: begin
                word0_d = bus.mem_rd_data;
                state_d = flush ? IDLE : WAIT;
            end
            WAIT: begin
                state_d = flush ? IDLE : RESP;
                if (!flush) begin
                    rsp_data_d = ext;
                    rsp_rd_d   = rd_q;
                    rsp_err_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            type_q     <= '0;
            rd_q       <= '0;
            cross_q    <= 1'b0;
            word0_q    <= '0;
            rsp_data_q <= '0;
            rsp_rd_q   <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            type_q     <= type_d;
            rd_q       <= rd_d;
            cross_q    <= cross_d;
            word0_q    <= word0_d;
            rsp_data_q <= rsp_data_d;
            rsp_rd_q   <= rsp_rd_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign bus.req_ready   = state_q == IDLE;
    assign bus.mem_rd_en   = state_q == RD0 || state_q == RD1;
    assign bus.mem_rd_addr = state_q == RD0 ? base : state_q == RD1 ? base + XLEN'(BYTES) : '0;
    assign bus.rsp_valid   = state_q == RESP && !flush;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_rd      = rsp_rd_q;
    assign bus.rsp_err     = rsp_err_q;
endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: three units (RV32 split, RV32 error-on-misalign, RV64 split)
// against a byte-addressed memory model and an expected-response queue.
module tb_load_align_unit;
    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        err;
        logic [3:0]  lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] vld = '0, fl = '0;
    logic [63:0] q_addr = '0;
    logic [2:0]  q_type = '0;
    logic [4:0]  q_rd = '0;
    logic [2:0]  rv, rr, ren, rer;
    logic [63:0] rdat [3];
    logic [63:0] raddr [3];
    logic [4:0]  rrd [3];
    logic [7:0]  bmem [logic [63:0]];
    logic [65:0] rdlog [$];
    exp_t sb [$];
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    load_align_unit_if #(.XLEN(32)) i0 ();
    load_align_unit_if #(.XLEN(32)) i1 ();
    load_align_unit_if #(.XLEN(64)) i2 ();

    load_align_unit #(.XLEN(32), .MISALIGN_EN(1'b1)) d0 (.clk(clk), .rst_n(rst_n), .flush(fl[0]), .bus(i0));
    load_align_unit #(.XLEN(32), .MISALIGN_EN(1'b0)) d1 (.clk(clk), .rst_n(rst_n), .flush(fl[1]), .bus(i1));
    load_align_unit #(.XLEN(64), .MISALIGN_EN(1'b1)) d2 (.clk(clk), .rst_n(rst_n), .flush(fl[2]), .bus(i2));

    assign i0.req_valid = vld[0];
    assign i1.req_valid = vld[1];
    assign i2.req_valid = vld[2];
    assign i0.req_addr = q_addr[31:0];
    assign i1.req_addr = q_addr[31:0];
    assign i2.req_addr = q_addr;
    assign i0.req_load_type = q_type;
    assign i1.req_load_type = q_type;
    assign i2.req_load_type = q_type;
    assign i0.req_rd = q_rd;
    assign i1.req_rd = q_rd;
    assign i2.req_rd = q_rd;
    assign rv  = {i2.rsp_valid, i1.rsp_valid, i0.rsp_valid};
    assign rr  = {i2.req_ready, i1.req_ready, i0.req_ready};
    assign ren = {i2.mem_rd_en, i1.mem_rd_en, i0.mem_rd_en};
    assign rer = {i2.rsp_err, i1.rsp_err, i0.rsp_err};
    assign rdat[0] = {32'd0, i0.rsp_data};
    assign rdat[1] = {32'd0, i1.rsp_data};
    assign rdat[2] = i2.rsp_data;
    assign raddr[0] = {32'd0, i0.mem_rd_addr};
    assign raddr[1] = {32'd0, i1.mem_rd_addr};
    assign raddr[2] = i2.mem_rd_addr;
    assign rrd[0] = i0.rsp_rd;
    assign rrd[1] = i1.rsp_rd;
    assign rrd[2] = i2.rsp_rd;

    function automatic logic [7:0] byte_at(input logic [63:0] a);
        return bmem.exists(a) ? bmem[a] : a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [63:0] rdword(input int nb, input logic [63:0] a);
        logic [63:0] r = '0;
        for (int i = 0; i < nb; i++) r[8*i +: 8] = byte_at(a + 64'(i));
        return r;
    endfunction

    task automatic set_word(input logic [63:0] a, input logic [63:0] w, input int nb);
        for (int i = 0; i < nb; i++) bmem[a + 64'(i)] = w[8*i +: 8];
    endtask

    // memory answers one cycle after each read strobe; every read is logged as {unit, addr}
    always @(posedge clk) begin
        if (i0.mem_rd_en) begin
            i0.mem_rd_data <= rdword(4, raddr[0])[31:0];
            rdlog.push_back({2'd0, raddr[0]});
        end
        if (i1.mem_rd_en) begin
            i1.mem_rd_data <= rdword(4, raddr[1])[31:0];
            rdlog.push_back({2'd1, raddr[1]});
        end
        if (i2.mem_rd_en) begin
            i2.mem_rd_data <= rdword(8, raddr[2]);
            rdlog.push_back({2'd2, raddr[2]});
        end
    end

    function automatic logic [65:0] rdl(input int i);
        return rdlog.size() > i ? rdlog[i] : '1;
    endfunction

    // byte-gathering reference: collect size bytes from the address, then extend
    function automatic exp_t model(input int nb, input bit mis_en, input logic [63:0] a,
                                   input logic [2:0] t, input logic [4:0] rd);
        exp_t e;
        int sz;
        logic [63:0] v, m;
        sz = (t == 1 || t == 4) ? 1 : (t == 2 || t == 5) ? 2 : (t == 3 || t == 6) ? 4 : 8;
        m = nb == 4 ? 64'hFFFF_FFFF : '1;
        e.rd = rd;
        if ((nb == 4 && t >= 6) || (!mis_en && (a % 64'(sz)) != 0)) begin
            e.data = '0;
            e.err = 1'b1;
            e.lat = 4'd1;
            return e;
        end
        v = '0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = byte_at((a + 64'(i)) & m);
        if (t <= 3 && v[8*sz-1]) for (int i = 8 * sz; i < 64; i++) v[i] = 1'b1;
        e.data = v & m;
        e.err = 1'b0;
        e.lat = (int'(a % 64'(nb)) + sz > nb) ? 4'd4 : 4'd3;
        return e;
    endfunction

    task automatic send(input int s, input logic [63:0] a, input logic [2:0] t, input logic [4:0] rd);
        q_addr = a;
        q_type = t;
        q_rd = rd;
        vld[s] = 1'b1;
        @(negedge clk);
        vld[s] = 1'b0;
    endtask

    task automatic collect(input int s, output bit got, output logic [3:0] lat, output logic [63:0] d,
                           output logic [4:0] rd, output logic err);
        got = 1'b0;
        lat = '0;
        d = '0;
        rd = '0;
        err = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (rv[s]) begin
                got = 1'b1;
                lat = 4'(i);
                d = rdat[s];
                rd = rrd[s];
                err = rer[s];
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            total++;
            if ({rr[s], rv[s], ren[s], rer[s], rdat[s], rrd[s], raddr[s]} !== {1'b1, 3'b000, 64'd0, 5'd0, 64'd0}) begin
                bad++;
                $display("FAIL reset unit%0d: ready=%b valid=%b rd_en=%b err=%b data=%h rd=%0d addr=%h, want ready=1 rest 0",
                         s, rr[s], rv[s], ren[s], rer[s], rdat[s], rrd[s], raddr[s]);
            end
        end
    endtask

    task automatic test_rv32_loads();
        bit got;
        logic [3:0] lat;
        logic [63:0] d;
        logic [4:0] rd;
        logic err;
        exp_t e;
        set_word(64'h100, 64'h8012_3456, 4);
        set_word(64'h200, 64'hAB00_0000, 4);
        set_word(64'h204, 64'h0000_00CD, 4);
        set_word(64'hFFFF_FFFC, 64'h4433_2211, 4);
        set_word(64'h0, 64'h8877_6655, 4);
        for (int k = 0; k < 4; k++) begin
            logic [63:0] a, w1;
            logic [2:0] t;
            logic [65:0] r0, r1;
            int nr;
            case (k)
                0: begin a = 64'h103; t = 3'd1; sb.push_back('{64'hFFFF_FF80, 5'd1, 1'b0, 4'd3}); r0 = {2'd0, 64'h100}; r1 = '1; nr = 1; end
                1: begin a = 64'h203; t = 3'd5; sb.push_back('{64'h0000_CDAB, 5'd2, 1'b0, 4'd4}); r0 = {2'd0, 64'h200}; r1 = {2'd0, 64'h204}; nr = 2; end
                2: begin a = 64'h203; t = 3'd2; sb.push_back('{64'hFFFF_FFAB, 5'd3, 1'b0, 4'd4}); r0 = {2'd0, 64'h200}; r1 = {2'd0, 64'h204}; nr = 2; end
                default: begin a = 64'hFFFF_FFFE; t = 3'd3; sb.push_back('{64'h6655_4433, 5'd4, 1'b0, 4'd4}); r0 = {2'd0, 64'hFFFF_FFFC}; r1 = {2'd0, 64'h0}; nr = 2; end
            endcase
            w1 = k == 2 ? 64'hFF : 64'hCD;
            set_word(64'h204, w1, 4);
            rdlog.delete();
            send(0, a, t, 5'(k + 1));
            total++;
            if (rr[0] !== 1'b0) begin
                bad++;
                $display("FAIL busy_ready%0d: req_ready=%b want 0", k, rr[0]);
            end
            collect(0, got, lat, d, rd, err);
            e = sb.pop_front();
            total++;
            if ({got, lat, d, rd, err} !== {1'b1, e.lat, e.data, e.rd, e.err}) begin
                bad++;
                $display("FAIL rv32_load%0d: got=%b lat=%0d data=%h rd=%0d err=%b, want lat=%0d data=%h rd=%0d err=0",
                         k, got, lat, d, rd, err, e.lat, e.data, e.rd);
            end
            total++;
            if ({rdlog.size(), rdl(0), rdl(1)} !== {nr, r0, r1}) begin
                bad++;
                $display("FAIL rv32_reads%0d: n=%0d r0=%h r1=%h, want n=%0d r0=%h r1=%h", k, rdlog.size(), rdl(0), rdl(1), nr, r0, r1);
            end
            @(negedge clk);
            total++;
            if ({rv[0], rdat[0], rrd[0]} !== {1'b0, e.data, e.rd}) begin
                bad++;
                $display("FAIL rsp_hold%0d: valid=%b data=%h rd=%0d, want valid=0 data=%h rd=%0d", k, rv[0], rdat[0], rrd[0], e.data, e.rd);
            end
        end
    endtask

    task automatic test_errors();
        bit got;
        logic [3:0] lat;
        logic [63:0] d;
        logic [4:0] rd;
        logic err;
        exp_t e;
        int s;
        for (int k = 0; k < 5; k++) begin
            logic [63:0] a;
            logic [2:0] t;
            int nr;
            case (k)
                0: begin s = 1; a = 64'h100; t = 3'd3; sb.push_back('{64'h8012_3456, 5'd10, 1'b0, 4'd3}); nr = 1; end
                1: begin s = 1; a = 64'h2; t = 3'd3; sb.push_back('{64'd0, 5'd11, 1'b1, 4'd1}); nr = 0; end
                2: begin s = 1; a = 64'h201; t = 3'd2; sb.push_back('{64'd0, 5'd12, 1'b1, 4'd1}); nr = 0; end
                3: begin s = 0; a = 64'h100; t = 3'd7; sb.push_back('{64'd0, 5'd13, 1'b1, 4'd1}); nr = 0; end
                default: begin s = 0; a = 64'h100; t = 3'd6; sb.push_back('{64'd0, 5'd14, 1'b1, 4'd1}); nr = 0; end
            endcase
            rdlog.delete();
            send(s, a, t, 5'(10 + k));
            collect(s, got, lat, d, rd, err);
            e = sb.pop_front();
            total++;
            if ({got, lat, d, rd, err} !== {1'b1, e.lat, e.data, e.rd, e.err}) begin
                bad++;
                $display("FAIL error_case%0d: got=%b lat=%0d data=%h rd=%0d err=%b, want lat=%0d data=%h rd=%0d err=%b",
                         k, got, lat, d, rd, err, e.lat, e.data, e.rd, e.err);
            end
            total++;
            if (rdlog.size() !== nr) begin
                bad++;
                $display("FAIL error_reads%0d: reads=%0d want %0d", k, rdlog.size(), nr);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rv64();
        bit got;
        logic [3:0] lat;
        logic [63:0] d;
        logic [4:0] rd;
        logic err;
        exp_t e;
        set_word(64'h100, 64'h1122_3344_5566_7788, 8);
        set_word(64'h108, 64'h99AA_BBCC_DDEE_FF00, 8);
        for (int k = 0; k < 4; k++) begin
            logic [63:0] a;
            logic [2:0] t;
            logic [65:0] r1;
            int nr;
            case (k)
                0: begin a = 64'h105; t = 3'd7; sb.push_back('{64'hCCDD_EEFF_0011_2233, 5'd20, 1'b0, 4'd4}); nr = 2; r1 = {2'd2, 64'h108}; end
                1: begin a = 64'h103; t = 3'd7; sb.push_back('{64'hEEFF_0011_2233_4455, 5'd21, 1'b0, 4'd4}); nr = 2; r1 = {2'd2, 64'h108}; end
                2: begin a = 64'h104; t = 3'd6; sb.push_back('{64'h0000_0000_1122_3344, 5'd22, 1'b0, 4'd3}); nr = 1; r1 = '1; end
                default: begin a = 64'h10C; t = 3'd3; sb.push_back('{64'hFFFF_FFFF_99AA_BBCC, 5'd23, 1'b0, 4'd3}); nr = 1; r1 = '1; end
            endcase
            rdlog.delete();
            send(2, a, t, 5'(20 + k));
            collect(2, got, lat, d, rd, err);
            e = sb.pop_front();
            total++;
            if ({got, lat, d, rd, err} !== {1'b1, e.lat, e.data, e.rd, e.err}) begin
                bad++;
                $display("FAIL rv64_load%0d: got=%b lat=%0d data=%h rd=%0d err=%b, want lat=%0d data=%h rd=%0d err=0",
                         k, got, lat, d, rd, err, e.lat, e.data, e.rd);
            end
            total++;
            if ({rdlog.size(), rdl(0) & {2'b11, 64'hFFFF_FFFF_FFFF_FFF8}, rdl(1)} !== {nr, {2'd2, a & ~64'h7}, r1}) begin
                bad++;
                $display("FAIL rv64_reads%0d: n=%0d r0=%h r1=%h, want n=%0d r1=%h", k, rdlog.size(), rdl(0), rdl(1), nr, r1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flush();
        bit got, seen;
        logic [3:0] lat;
        logic [63:0] d;
        logic [4:0] rd;
        logic err;
        exp_t e;
        set_word(64'h100, 64'h8012_3456, 4);
        send(0, 64'h203, 3'd5, 5'd5);
        @(negedge clk);
        fl[0] = 1'b1;
        @(negedge clk);
        fl[0] = 1'b0;
        total++;
        if (rr[0] !== 1'b1) begin
            bad++;
            $display("FAIL flush_ready: req_ready=%b want 1", rr[0]);
        end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen |= rv[0];
            @(negedge clk);
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL flush_no_rsp: rsp_valid seen=%b want 0", seen);
        end
        sb.push_back('{64'h8012_3456, 5'd6, 1'b0, 4'd3});
        rdlog.delete();
        send(0, 64'h100, 3'd3, 5'd6);
        collect(0, got, lat, d, rd, err);
        e = sb.pop_front();
        total++;
        if ({got, lat, d, rd, err, rdl(0)} !== {1'b1, e.lat, e.data, e.rd, e.err, {2'd0, 64'h100}}) begin
            bad++;
            $display("FAIL flush_next_lw: got=%b lat=%0d data=%h rd=%0d err=%b read=%h, want lat=3 data=%h rd=6 read @100",
                     got, lat, d, rd, err, rdl(0), e.data);
        end
        @(negedge clk);
        // a request colliding with flush must be dropped
        rdlog.delete();
        fl[0] = 1'b1;
        send(0, 64'h100, 3'd3, 5'd7);
        fl[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen |= rv[0] | ~rr[0];
            @(negedge clk);
        end
        total++;
        if ({seen, rdlog.size()} !== {1'b0, 32'd0}) begin
            bad++;
            $display("FAIL flush_collide: busy_or_rsp=%b reads=%0d, want 0 and 0", seen, rdlog.size());
        end
    endtask

    task automatic test_reset_and_noreg();
        bit seen;
        send(0, 64'h203, 3'd5, 5'd8);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({rv[0], ren[0], rer[0], rdat[0], rrd[0], raddr[0]} !== '0) begin
            bad++;
            $display("FAIL midreset: valid=%b rd_en=%b err=%b data=%h rd=%0d addr=%h, want all 0",
                     rv[0], ren[0], rer[0], rdat[0], rrd[0], raddr[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen |= rv[0] | ~rr[0];
            @(negedge clk);
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL midreset_after: rsp or busy seen=%b want 0", seen);
        end
        rdlog.delete();
        send(0, 64'h100, 3'd0, 5'd9);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen |= rv[0] | ~rr[0];
            @(negedge clk);
        end
        total++;
        if ({seen, rdlog.size()} !== {1'b0, 32'd0}) begin
            bad++;
            $display("FAIL noreg: rsp_or_busy=%b reads=%0d, want 0 and 0", seen, rdlog.size());
        end
    endtask

    task automatic test_back_to_back();
        bit got;
        logic [3:0] lat;
        logic [63:0] d;
        logic [4:0] rd;
        logic err;
        exp_t e;
        for (int n = 0; n < 40; n++) begin
            int s;
            logic [63:0] a;
            logic [2:0] t;
            logic [4:0] r;
            s = n < 20 ? 0 : 2;
            a = (n % 5 == 4) ? (s == 0 ? 64'hFFFF_FFF8 : '1 - 64'h7) + 64'($urandom_range(0, 7))
                             : 64'h300 + 64'($urandom_range(0, 31));
            t = 3'($urandom_range(1, 7));
            r = 5'($urandom);
            sb.push_back(model(s == 0 ? 4 : 8, 1'b1, a, t, r));
            send(s, a, t, r);
            collect(s, got, lat, d, rd, err);
            e = sb.pop_front();
            total++;
            if ({got, lat, d, rd, err} !== {1'b1, e.lat, e.data, e.rd, e.err}) begin
                bad++;
                $display("FAIL b2b%0d unit%0d addr=%h type=%0d: got=%b lat=%0d data=%h rd=%0d err=%b, want lat=%0d data=%h rd=%0d err=%b",
                         n, s, a, t, got, lat, d, rd, err, e.lat, e.data, e.rd, e.err);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_rv32_loads();
        test_errors();
        test_rv64();
        test_flush();
        test_reset_and_noreg();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
